uart_cmd_wrapper: RTL

Byte-level front end of the quadcopter command path: it assembles three UART bytes (command, data high, data low) into a 24-bit command frame for the command-configuration block. It holds `cmd_rdy` until that block acknowledges with `clr_cmd_rdy`. It also returns the block's 8-bit responses (`resp`/`send_resp`) to the UART transmitter through a one-entry pending buffer. It sits between the UART RX/TX macros and the command-configuration block.

---
 rtl/uart_cmd_wrapper.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
// Byte-level front end of the quadcopter command path.
//  - RX side: assembles three UART bytes (command, data high, data low) into
//    a cmd/data frame, raises cmd_rdy and holds it until clr_cmd_rdy.
//    A partial frame that stalls for FRAME_TMO cycles is discarded and
//    reported with a one-cycle frame_err pulse.
//  - TX side: forwards response bytes to the UART transmitter, with a
//    one-entry pending buffer; a response arriving while both the
//    transmitter and the buffer are occupied is dropped (resp_ovf pulse).
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  rx_rdy, rx_data          byte available from UART RX
//  clr_rx_rdy               one-cycle pulse consuming the rx byte
//  cmd, data, cmd_rdy       last completed frame and its valid flag
//  clr_cmd_rdy              frame acknowledge from command-config block
//  resp, send_resp          response byte and its one-cycle request
//  trmt, tx_data, tx_done   UART TX start pulse, byte, and completion pulse
//  resp_busy                high while a byte is in flight on UART TX
//  frame_err, resp_ovf      one-cycle error pulses
module uart_cmd_wrapper #(
  parameter int FRAME_TMO = 5000,
  parameter int TMO_W     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        frame_err,
  output logic        resp_ovf
);

  typedef enum logic [1:0] {CMD, HI, LO, RDY} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TMO - 1);

  // ---------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------
  rx_state_t        rx_state, rx_state_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]       cmd_sh, cmd_sh_nxt;
  logic [7:0]       hi_sh, hi_sh_nxt;
  logic [7:0]       cmd_nxt;
  logic [15:0]      data_nxt;
  logic             cmd_rdy_nxt;
  logic             clr_rx_rdy_nxt;
  logic             frame_err_nxt;
  logic             accept;

  // A byte is taken only while collecting a frame, and never in the cycle
  // the previous byte is being cleared (rx_rdy may still be high then).
  assign accept = rx_rdy && !clr_rx_rdy && (rx_state != RDY);

  always_comb begin
    rx_state_nxt   = rx_state;
    tmo_cnt_nxt    = tmo_cnt;
    cmd_sh_nxt     = cmd_sh;
    hi_sh_nxt      = hi_sh;
    cmd_nxt        = cmd;
    data_nxt       = data;
    cmd_rdy_nxt    = cmd_rdy;
    clr_rx_rdy_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (rx_state)
      CMD: begin
        tmo_cnt_nxt = '0;
        if (accept) begin
          clr_rx_rdy_nxt = 1'b1;
          cmd_sh_nxt     = rx_data;
          rx_state_nxt   = HI;
        end
      end
      HI, LO: begin
        // An arriving byte takes priority over the timeout expiring.
        if (accept) begin
          clr_rx_rdy_nxt = 1'b1;
          tmo_cnt_nxt    = '0;
          if (rx_state == HI) begin
            hi_sh_nxt    = rx_data;
            rx_state_nxt = LO;
          end else begin
            cmd_nxt      = cmd_sh;
            data_nxt     = {hi_sh, rx_data};
            cmd_rdy_nxt  = 1'b1;
            rx_state_nxt = RDY;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          frame_err_nxt = 1'b1;
          tmo_cnt_nxt   = '0;
          rx_state_nxt  = CMD;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      RDY: begin
        tmo_cnt_nxt = '0;
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt  = 1'b0;
          rx_state_nxt = CMD;
        end
      end
      default: rx_state_nxt = CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= CMD;
      tmo_cnt    <= '0;
      cmd_sh     <= '0;
      hi_sh      <= '0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
      clr_rx_rdy <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      cmd_sh     <= cmd_sh_nxt;
      hi_sh      <= hi_sh_nxt;
      cmd        <= cmd_nxt;
      data       <= data_nxt;
      cmd_rdy    <= cmd_rdy_nxt;
      clr_rx_rdy <= clr_rx_rdy_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------
  tx_state_t  tx_state, tx_state_nxt;
  logic [7:0] tx_data_nxt;
  logic [7:0] pend_byte, pend_byte_nxt;
  logic       pend_vld, pend_vld_nxt;
  logic       trmt_nxt;
  logic       resp_ovf_nxt;

  always_comb begin
    tx_state_nxt  = tx_state;
    tx_data_nxt   = tx_data;
    pend_byte_nxt = pend_byte;
    pend_vld_nxt  = pend_vld;
    trmt_nxt      = 1'b0;
    resp_ovf_nxt  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_nxt  = resp;
          trmt_nxt     = 1'b1;
          tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          if (pend_vld) begin
            // Launch the buffered byte; a simultaneous request refills
            // the slot just freed.
            tx_data_nxt = pend_byte;
            trmt_nxt    = 1'b1;
            if (send_resp) begin
              pend_byte_nxt = resp;
            end else begin
              pend_vld_nxt = 1'b0;
            end
          end else if (send_resp) begin
            tx_data_nxt = resp;
            trmt_nxt    = 1'b1;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end else if (send_resp) begin
          if (!pend_vld) begin
            pend_byte_nxt = resp;
            pend_vld_nxt  = 1'b1;
          end else begin
            resp_ovf_nxt = 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_data   <= '0;
      pend_byte <= '0;
      pend_vld  <= 1'b0;
      trmt      <= 1'b0;
      resp_ovf  <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_data   <= tx_data_nxt;
      pend_byte <= pend_byte_nxt;
      pend_vld  <= pend_vld_nxt;
      trmt      <= trmt_nxt;
      resp_ovf  <= resp_ovf_nxt;
    end
  end

  assign resp_busy = (tx_state == TX_BUSY);

endmodule
